// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension arbiter slice.
// Mode 11 (upper-immediate) support is selected by IMM_EXT_LUI_MODE_EN in imm_ext_datapath.
package imm_ext_pkg;

    localparam int unsigned DEF_IMM_W  = 16;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_ZERO      = 2'b00,
        MODE_SIGN      = 2'b01,
        MODE_SIGN_SHL2 = 2'b10,
        MODE_LUI       = 2'b11
    } imm_mode_e;

    localparam logic REQ_DECODE = 1'b0;
    localparam logic REQ_BRANCH = 1'b1;

endpackage

// File: rtl/imm_ext_datapath.sv
// Combinational immediate extender: zero/sign/sign-shl2/upper-immediate.
// Macro IMM_EXT_LUI_MODE_EN: defined -> mode 11 yields {imm, zeros};
// undefined -> mode 11 yields zero with err set.
module imm_ext_datapath
    import imm_ext_pkg::*;
#(
    parameter int unsigned IMM_W  = DEF_IMM_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    logic [DATA_W-1:0] ext_zero;
    logic [DATA_W-1:0] ext_sign;

    assign ext_zero = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign ext_sign = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Select the extension; shift is applied after sign extension.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (mode)
            MODE_ZERO:      result = ext_zero;
            MODE_SIGN:      result = ext_sign;
            MODE_SIGN_SHL2: result = {ext_sign[DATA_W-3:0], 2'b00};
            default: begin
`ifdef IMM_EXT_LUI_MODE_EN
                result = {imm, {(DATA_W-IMM_W){1'b0}}};
                err    = 1'b0;
`else
                result = '0;
                err    = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between decode (0) and
// branch (1), with a one-deep registered response buffer.
// Optional macro IMM_EXT_LUI_MODE_EN enables mode 11 inside imm_ext_datapath.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int unsigned IMM_W  = DEF_IMM_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ReqValid,
    input  logic [IMM_W-1:0]  ReqImm0,
    input  logic [IMM_W-1:0]  ReqImm1,
    input  logic [1:0]        ReqMode0,
    input  logic [1:0]        ReqMode1,
    output logic [1:0]        ReqReady,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] RespData,
    output logic              RespId,
    output logic              RespErr
);

    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_id_q;
    logic              resp_err_q;
    logic              last_grant_q;

    logic              free;
    logic [1:0]        grant;
    logic              sel;
    logic              transfer;
    logic [IMM_W-1:0]  sel_imm;
    logic [1:0]        sel_mode;
    logic [DATA_W-1:0] dp_result;
    logic              dp_err;

    assign free = !resp_valid_q || RespReady;

    // Round-robin grant: on contention, the requester not granted last wins.
    always_comb begin
        grant = 2'b00;
        if (free) begin
            case (ReqValid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant_q == REQ_BRANCH) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Grant already implies the requester is valid.
    assign transfer = |grant;
    assign sel      = grant[1] ? REQ_BRANCH : REQ_DECODE;
    assign sel_imm  = grant[1] ? ReqImm1 : ReqImm0;
    assign sel_mode = grant[1] ? ReqMode1 : ReqMode0;

    imm_ext_datapath #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_datapath (
        .imm    (sel_imm),
        .mode   (sel_mode),
        .result (dp_result),
        .err    (dp_err)
    );

    // Output buffer and arbitration pointer; a new transfer overrides a drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= REQ_DECODE;
            resp_err_q   <= 1'b0;
            last_grant_q <= REQ_BRANCH;
        end else if (transfer) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= dp_result;
            resp_id_q    <= sel;
            resp_err_q   <= dp_err;
            last_grant_q <= sel;
        end else if (RespReady) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign ReqReady  = grant;
    assign RespValid = resp_valid_q;
    assign RespData  = resp_data_q;
    assign RespId    = resp_id_q;
    assign RespErr   = resp_err_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed self-checking bench for imm_ext_arbiter.
// Expected mode-11 behaviour follows IMM_EXT_LUI_MODE_EN when the bench is built.
module tb_imm_ext_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  ReqValid;
    logic [15:0] ReqImm0;
    logic [15:0] ReqImm1;
    logic [1:0]  ReqMode0;
    logic [1:0]  ReqMode1;
    logic [1:0]  ReqReady;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespId;
    logic        RespErr;

    int checks;
    int failures;

    imm_ext_arbiter #(
        .IMM_W  (16),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqImm0   (ReqImm0),
        .ReqImm1   (ReqImm1),
        .ReqMode0  (ReqMode0),
        .ReqMode1  (ReqMode1),
        .ReqReady  (ReqReady),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespData  (RespData),
        .RespId    (RespId),
        .RespErr   (RespErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  mode_vec [3];
    logic [31:0] mode_exp [3];
    logic [31:0] lui_data;
    logic        lui_err;
    logic        exp_id;

    initial begin
        checks   = 0;
        failures = 0;
        mode_vec[0] = 2'b00; mode_exp[0] = 32'h0000_8004;
        mode_vec[1] = 2'b01; mode_exp[1] = 32'hFFFF_8004;
        mode_vec[2] = 2'b10; mode_exp[2] = 32'hFFFE_0010;
`ifdef IMM_EXT_LUI_MODE_EN
        lui_data = 32'h1234_0000;
        lui_err  = 1'b0;
`else
        lui_data = 32'h0000_0000;
        lui_err  = 1'b1;
`endif

        reset     = 1'b1;
        ReqValid  = 2'b00;
        ReqImm0   = 16'h0;
        ReqImm1   = 16'h0;
        ReqMode0  = 2'b00;
        ReqMode1  = 2'b00;
        RespReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(RespValid), 32'd0);
        chk("rst_data",  RespData,       32'd0);
        chk("rst_id",    32'(RespId),    32'd0);
        chk("rst_err",   32'(RespErr),   32'd0);
        chk("rst_ready", 32'(ReqReady),  32'd0);
        reset = 1'b0;

        // Fill the buffer so a later reset lands mid-stream.
        ReqValid = 2'b10;
        ReqImm1  = 16'h00FF;
        ReqMode1 = 2'b00;
        #1;
        chk("fill_ready", 32'(ReqReady), 32'h2);
        step();
        chk("fill_valid", 32'(RespValid), 32'd1);
        chk("fill_data",  RespData,       32'h0000_00FF);
        chk("fill_id",    32'(RespId),    32'd1);
        ReqValid = 2'b00;

        // Asynchronous reset with a buffered result, no clock edge needed.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(RespValid), 32'd0);
        chk("arst_data",  RespData,       32'd0);
        chk("arst_id",    32'(RespId),    32'd0);
        ReqValid = 2'b11;
        #1;
        chk("arst_ready", 32'(ReqReady), 32'h1);
        #1;
        reset = 1'b0;

        // Round-robin from reset: 0,1,0,1 with continuous output.
        ReqImm0   = 16'h0011;
        ReqMode0  = 2'b00;
        ReqImm1   = 16'h0022;
        ReqMode1  = 2'b00;
        RespReady = 1'b1;
        #1;
        chk("rr_first_ready", 32'(ReqReady), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_id = (i % 2 == 1);
            chk("rr_valid", 32'(RespValid), 32'd1);
            chk("rr_id",    32'(RespId),    32'(exp_id));
            chk("rr_data",  RespData,       exp_id ? 32'h22 : 32'h11);
            chk("rr_ready", 32'(ReqReady),  exp_id ? 32'h1 : 32'h2);
        end
        ReqValid = 2'b00;
        step();
        chk("rr_drain_valid", 32'(RespValid), 32'd0);
        chk("rr_drain_data",  RespData,       32'h22);
        chk("rr_drain_id",    32'(RespId),    32'd1);

        // Single requester through each supported mode.
        ReqValid = 2'b01;
        ReqImm0  = 16'h8004;
        for (int m = 0; m < 3; m++) begin
            ReqMode0 = mode_vec[m];
            step();
            chk("mode_valid", 32'(RespValid), 32'd1);
            chk("mode_data",  RespData,       mode_exp[m]);
            chk("mode_id",    32'(RespId),    32'd0);
            chk("mode_err",   32'(RespErr),   32'd0);
        end

        // Upper-immediate mode from the branch requester.
        ReqValid = 2'b10;
        ReqImm1  = 16'h1234;
        ReqMode1 = 2'b11;
        step();
        chk("lui_valid", 32'(RespValid), 32'd1);
        chk("lui_data",  RespData,       lui_data);
        chk("lui_err",   32'(RespErr),   32'(lui_err));
        chk("lui_id",    32'(RespId),    32'd1);

        // Backpressure: nothing granted, outputs frozen.
        RespReady = 1'b0;
        ReqValid  = 2'b01;
        ReqImm0   = 16'h00AA;
        ReqMode0  = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(ReqReady),  32'd0);
            chk("bp_valid", 32'(RespValid), 32'd1);
            chk("bp_data",  RespData,       lui_data);
            chk("bp_id",    32'(RespId),    32'd1);
            step();
        end

        // Release: drain and accept together; pointer advanced past branch.
        ReqValid  = 2'b11;
        RespReady = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ReqReady), 32'h1);
        step();
        chk("bp_accept_valid", 32'(RespValid), 32'd1);
        chk("bp_accept_data",  RespData,       32'h0000_00AA);
        chk("bp_accept_id",    32'(RespId),    32'd0);
        chk("bp_accept_err",   32'(RespErr),   32'd0);

        // Drain without a new request.
        ReqValid  = 2'b00;
        RespReady = 1'b0;
        step();
        chk("hold_valid", 32'(RespValid), 32'd1);
        RespReady = 1'b1;
        step();
        chk("drain_valid", 32'(RespValid), 32'd0);
        chk("drain_data",  RespData,       32'h0000_00AA);
        chk("drain_id",    32'(RespId),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
